multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/opcode_classify.sv | 31 +++
 rtl/multicycle_ctrl.sv | 123 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I-subset definitions: FSM state encodings and major opcode constants.
// Used by the multicycle controller and the immediate generator.
package riscv_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode-class decode; exactly one of the six class flags is high.
module opcode_classify
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_r,
  output logic       is_i,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_illegal
);

  always_comb begin
    is_r       = 1'b0;
    is_i       = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE:  is_r       = 1'b1;
      OP_ITYPE:  is_i       = 1'b1;
      OP_LOAD:   is_load    = 1'b1;
      OP_STORE:  is_store   = 1'b1;
      OP_BRANCH: is_branch  = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing with sticky HALT.
// Build option MEM_READY_EN: FETCH and MEM stall with mem_req held until mem_ready.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic       alu_src_imm,
  output logic       mem_to_reg,
  output logic       pc_src_branch,
  output logic [2:0] state,
  output logic       halted
);

  state_e state_q, state_d;
  logic   run_q, run_d;
  logic   mem_done;
  logic   is_r, is_i, is_load, is_store, is_branch, is_illegal;

  opcode_classify u_classify (
    .opcode     (opcode),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_illegal (is_illegal)
  );

`ifdef MEM_READY_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done         = 1'b1;
`endif

  // run_q keeps every output quiet from reset until the first clock edge after release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_write     = 1'b0;
    alu_src_imm   = 1'b0;
    mem_to_reg    = 1'b0;
    pc_src_branch = 1'b0;
    halted        = 1'b0;
    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_done) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          state_d = is_illegal ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_src_imm = is_i | is_load | is_store;
          if (is_branch) begin
            pc_src_branch = 1'b1;
            pc_write      = zero;
            state_d       = S_FETCH;
          end else if (is_load | is_store) begin
            state_d = S_MEM;
          end else if (is_r | is_i) begin
            state_d = S_WRITEBACK;
          end else begin
            // opcode changed under us after decode: stop rather than guess
            state_d = S_HALT;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_done) begin
            state_d = is_load ? S_WRITEBACK : S_FETCH;
          end
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = is_load;
          state_d    = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are queued
// per instruction and compared on the falling clock edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_req, mem_we, reg_write;
  logic       alu_src_imm, mem_to_reg, pc_src_branch;
  logic [2:0] state;
  logic       halted;

  int n_chk = 0;
  int n_bad = 0;
  logic [11:0] sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .ir_write      (ir_write),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .reg_write     (reg_write),
    .alu_src_imm   (alu_src_imm),
    .mem_to_reg    (mem_to_reg),
    .pc_src_branch (pc_src_branch),
    .state         (state),
    .halted        (halted)
  );

  // vector layout: {state, halted, pc_write, ir_write, mem_req, mem_we, reg_write, alu_src_imm, mem_to_reg, pc_src_branch}
  function automatic logic [11:0] vec(input logic [2:0] st, input logic h, input logic pcw,
                                      input logic irw, input logic mrq, input logic mwe,
                                      input logic rw, input logic alu, input logic m2r,
                                      input logic psb);
    return {st, h, pcw, irw, mrq, mwe, rw, alu, m2r, psb};
  endfunction

  function automatic logic [11:0] obs();
    return {state, halted, pc_write, ir_write, mem_req, mem_we, reg_write,
            alu_src_imm, mem_to_reg, pc_src_branch};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // expected per-cycle outputs for one instruction with no wait states
  task automatic push_instr(input logic [6:0] op, input logic z);
    sb.push_back(vec(3'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
    sb.push_back(vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      7'b0110011: begin
        sb.push_back(vec(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(vec(3'd4, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      7'b0010011: begin
        sb.push_back(vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(vec(3'd4, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      7'b0000011: begin
        sb.push_back(vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(vec(3'd3, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        sb.push_back(vec(3'd4, 0, 0, 0, 0, 0, 1, 0, 1, 0));
      end
      7'b0100011: begin
        sb.push_back(vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        sb.push_back(vec(3'd3, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      7'b1100011: begin
        sb.push_back(vec(3'd2, 0, z, 0, 0, 0, 0, 0, 0, 1));
      end
      default: begin
        for (int i = 0; i < 10; i++) sb.push_back(vec(3'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    endcase
  endtask

  // compares up to n queued vectors; the opcode for this instruction is applied during FETCH
  task automatic drain(input string tag, input int n, input logic [6:0] op, input logic z);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      e = sb.pop_front();
      check_val($sformatf("%s[%0d]", tag, i), {20'd0, obs()}, {20'd0, e});
      if (i == 0) begin
        opcode = op;
        zero   = z;
      end
    end
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic z);
    push_instr(op, z);
    drain(tag, sb.size(), op, z);
  endtask

  // reset pulse between clock edges; outputs must drop at once and stay quiet until the next edge
  task automatic reset_pulse(input string tag);
    #1 reset = 1'b1;
    #1 check_val({tag, "_during"}, {20'd0, obs()}, 32'd0);
    #1 reset = 1'b0;
    #1 check_val({tag, "_after"}, {20'd0, obs()}, 32'd0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 7'b0110011;
    zero      = 1'b0;
`ifdef MEM_READY_EN
    mem_ready = 1'b1;
`else
    mem_ready = 1'b0;
`endif
    #1 check_val("por_state", {29'd0, state}, 32'd0);
    check_val("por_outputs", {20'd0, obs()}, 32'd0);
    @(negedge clk);
    reset_pulse("rst0");

    run_instr("r_z1",     7'b0110011, 1'b1);
    run_instr("i_alu",    7'b0010011, 1'b0);
    run_instr("load",     7'b0000011, 1'b1);
    run_instr("store",    7'b0100011, 1'b0);
    run_instr("beq_t",    7'b1100011, 1'b1);
    run_instr("beq_nt",   7'b1100011, 1'b0);
    run_instr("load_b2b", 7'b0000011, 1'b0);
    run_instr("r_z0",     7'b0110011, 1'b0);

`ifdef MEM_READY_EN
    begin
      logic [11:0] e;
      sb.push_back(vec(3'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0));
      sb.push_back(vec(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      sb.push_back(vec(3'd2, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < 4; i++) sb.push_back(vec(3'd3, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        e = sb.pop_front();
        check_val($sformatf("st_wait[%0d]", i), {20'd0, obs()}, {20'd0, e});
        if (i == 0) opcode = 7'b0100011;
        if (i == 2) mem_ready = 1'b0;
        if (i == 6) mem_ready = 1'b1;
      end
    end
    run_instr("r_after_wait", 7'b0110011, 1'b0);
`endif

    run_instr("illegal", 7'b1111111, 1'b0);
    reset_pulse("halt_rst");
    run_instr("r_post_halt", 7'b0110011, 1'b1);

    push_instr(7'b0000011, 1'b0);
    drain("load_cut", 4, 7'b0000011, 1'b0);
    #1 reset = 1'b1;
    #1 check_val("midmem_state", {29'd0, state}, 32'd0);
    check_val("midmem_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("midmem_outputs", {20'd0, obs()}, 32'd0);
    #1 reset = 1'b0;
    #1 check_val("midmem_after", {20'd0, obs()}, 32'd0);
    sb.delete();
    run_instr("r_post_cut", 7'b0110011, 1'b0);
    run_instr("store_post_cut", 7'b0100011, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
